// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, memory request, {pc,instr} queue to decode
//
// Purpose:
//   Holds the program counter, presents it as a word address to instruction
//   memory, captures the returned word on the access-complete pulse and queues
//   {pc, instruction} pairs for decode. Redirects flush the queue and reload
//   the PC; misaligned redirect targets park the unit in a fault state.
//
// Optional feature:
//   IFU_PERF_COUNTERS_EN - adds saturating counters o_perf_fetched and
//   o_perf_hold_cycles (cleared by reset only).
//
// Ports:
//   i_clk, i_arst_n       clock, asynchronous active-low reset
//   o_mem_addr, o_mem_req fetch address (current PC) and request
//   i_mem_data, i_mem_access
//                         returned instruction word, single-cycle completion pulse
//   i_redirect_valid, i_redirect_pc
//                         PC reload from branch/jump resolution
//   o_dec_valid, o_dec_instr, o_dec_pc, i_dec_ready
//                         queue head to decode, valid/ready handshake
//   o_perf_fetched, o_perf_hold_cycles
//                         performance counters (IFU_PERF_COUNTERS_EN only)
//   o_fetch_fault         misaligned redirect target, held until next good redirect

module instr_fetch_unit #(
  parameter int unsigned              ADDR_WIDTH  = 64,
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = 64'h8000_0000,
  parameter int unsigned              QUEUE_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_req,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_access,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_dec_valid,
  output logic [DATA_WIDTH-1:0] o_dec_instr,
  output logic [ADDR_WIDTH-1:0] o_dec_pc,
  input  logic                  i_dec_ready,
`ifdef IFU_PERF_COUNTERS_EN
  output logic [31:0]           o_perf_fetched,
  output logic [31:0]           o_perf_hold_cycles,
`endif
  output logic                  o_fetch_fault
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  mem_req_q;
  logic                  fault_q;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;

  logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [QUEUE_DEPTH];

  logic push;
  logic pop;
  logic redirect_aligned;

  assign o_mem_addr    = pc;
  assign o_mem_req     = mem_req_q;
  assign o_fetch_fault = fault_q;
  assign o_dec_valid   = (count != '0);
  assign o_dec_instr   = instr_q[rd_ptr];
  assign o_dec_pc      = pc_q[rd_ptr];

  assign redirect_aligned = (i_redirect_pc[1:0] == 2'b00);

  // A redirect flushes the queue, so neither a pop nor a capture in that
  // cycle may touch the pointers. A capture into a full queue is only legal
  // when the head leaves in the same cycle.
  assign pop  = o_dec_valid & i_dec_ready & ~i_redirect_valid;
  assign push = (state == ST_FETCH) & i_mem_access & ~i_redirect_valid
              & ((count != FULL_CNT) | pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      mem_req_q <= 1'b1;
      fault_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (i_redirect_valid) begin
      pc     <= i_redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (redirect_aligned) begin
        state     <= ST_FETCH;
        mem_req_q <= 1'b1;
        fault_q   <= 1'b0;
      end else begin
        state     <= ST_FAULT;
        mem_req_q <= 1'b0;
        fault_q   <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;

      case (state)
        ST_FETCH: begin
          // Stop requesting once the capture fills the last free entry.
          if (push && (count_nxt == FULL_CNT)) begin
            state     <= ST_HOLD;
            mem_req_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Resume at the unchanged pc once decode frees an entry.
          if (pop) begin
            state     <= ST_FETCH;
            mem_req_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state     <= ST_FETCH;
          mem_req_q <= 1'b1;
        end
      endcase
    end
  end

  // Queue payload needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_q[wr_ptr] <= i_mem_data;
      pc_q[wr_ptr]    <= pc;
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_hold_q;

  assign o_perf_fetched     = perf_fetched_q;
  assign o_perf_hold_cycles = perf_hold_q;

  // Saturating; redirects deliberately leave the counts intact.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      perf_fetched_q <= '0;
      perf_hold_q    <= '0;
    end else begin
      if (push && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state == ST_HOLD) && (perf_hold_q != '1)) begin
        perf_hold_q <= perf_hold_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] RST_PC = 64'h8000_0000;

  logic          i_clk = 1'b0;
  logic          i_arst_n;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_req;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_access;
  logic          i_redirect_valid;
  logic [AW-1:0] i_redirect_pc;
  logic          o_dec_valid;
  logic [DW-1:0] o_dec_instr;
  logic [AW-1:0] o_dec_pc;
  logic          i_dec_ready;
  logic          o_fetch_fault;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0]   o_perf_fetched;
  logic [31:0]   o_perf_hold_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RST_PC),
    .QUEUE_DEPTH(2)
  ) dut (
    .i_clk            (i_clk),
    .i_arst_n         (i_arst_n),
    .o_mem_addr       (o_mem_addr),
    .o_mem_req        (o_mem_req),
    .i_mem_data       (i_mem_data),
    .i_mem_access     (i_mem_access),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_dec_valid      (o_dec_valid),
    .o_dec_instr      (o_dec_instr),
    .o_dec_pc         (o_dec_pc),
    .i_dec_ready      (i_dec_ready),
`ifdef IFU_PERF_COUNTERS_EN
    .o_perf_fetched    (o_perf_fetched),
    .o_perf_hold_cycles(o_perf_hold_cycles),
`endif
    .o_fetch_fault    (o_fetch_fault)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: mem_word = 32'h0000_0013;
      64'h8000_0004: mem_word = 32'h0010_0093;
      default:       mem_word = {a[15:0], 16'h0F13};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse();
    i_mem_data   = mem_word(o_mem_addr);
    i_mem_access = 1'b1;
    cyc(1);
    i_mem_access = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_addr"},  o_mem_addr, RST_PC);
    check_eq({tag, "_req"},   64'(o_mem_req), 64'd1);
    check_eq({tag, "_valid"}, 64'(o_dec_valid), 64'd0);
    check_eq({tag, "_fault"}, 64'(o_fetch_fault), 64'd0);
`ifdef IFU_PERF_COUNTERS_EN
    check_eq({tag, "_pfetch"}, 64'(o_perf_fetched), 64'd0);
    check_eq({tag, "_phold"},  64'(o_perf_hold_cycles), 64'd0);
`endif
  endtask

  task automatic do_reset();
    i_arst_n = 1'b0;
    cyc(2);
    check_reset_vals("rst");
    i_arst_n = 1'b1;
  endtask

  initial begin
    i_arst_n         = 1'b0;
    i_mem_data       = '0;
    i_mem_access     = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_dec_ready      = 1'b1;

    // Test 1: basic fetch with decode always ready
    do_reset();
    cyc(7);
    pulse();
    check_eq("t1_valid0", 64'(o_dec_valid), 64'd1);
    check_eq("t1_pc0",    o_dec_pc, 64'h8000_0000);
    check_eq("t1_ins0",   64'(o_dec_instr), 64'h0000_0013);
    check_eq("t1_addr0",  o_mem_addr, 64'h8000_0004);
    cyc(7);
    pulse();
    check_eq("t1_pc1",    o_dec_pc, 64'h8000_0004);
    check_eq("t1_ins1",   64'(o_dec_instr), 64'h0010_0093);
    check_eq("t1_addr1",  o_mem_addr, 64'h8000_0008);
    cyc(1);
    check_eq("t1_drained", 64'(o_dec_valid), 64'd0);

    // Test 2: backpressure fills the queue and enters HOLD
    do_reset();
    i_dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(7);
      pulse();
    end
    check_eq("t2_req_hold", 64'(o_mem_req), 64'd0);
    check_eq("t2_valid",    64'(o_dec_valid), 64'd1);
    check_eq("t2_head0",    o_dec_pc, 64'h8000_0000);
    check_eq("t2_addr",     o_mem_addr, 64'h8000_0008);
`ifdef IFU_PERF_COUNTERS_EN
    check_eq("t2_pfetch",   64'(o_perf_fetched), 64'd2);
    check_eq("t2_phold",    64'(o_perf_hold_cycles), 64'd24);
`endif
    i_dec_ready = 1'b1;
    cyc(1);
    check_eq("t2_head1",    o_dec_pc, 64'h8000_0004);
    check_eq("t2_ins1",     64'(o_dec_instr), 64'h0010_0093);
    check_eq("t2_req_res",  64'(o_mem_req), 64'd1);
    check_eq("t2_addr_res", o_mem_addr, 64'h8000_0008);
    cyc(1);
    check_eq("t2_empty",    64'(o_dec_valid), 64'd0);
    cyc(5);
    pulse();
    check_eq("t2_next_pc",  o_dec_pc, 64'h8000_0008);
    check_eq("t2_next_ins", 64'(o_dec_instr), 64'h0008_0F13);

    // Test 3: redirect coinciding with a pulse, one entry queued
    i_dec_ready = 1'b0;
    cyc(7);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'h8000_0100;
    pulse();
    i_redirect_valid = 1'b0;
    check_eq("t3_flush",   64'(o_dec_valid), 64'd0);
    check_eq("t3_addr",    o_mem_addr, 64'h8000_0100);
    check_eq("t3_req",     64'(o_mem_req), 64'd1);
    i_dec_ready = 1'b1;
    cyc(7);
    pulse();
    check_eq("t3_pc",      o_dec_pc, 64'h8000_0100);
    check_eq("t3_ins",     64'(o_dec_instr), 64'h0100_0F13);

    // Test 4: misaligned redirect faults, aligned redirect recovers
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'h8000_0102;
    cyc(1);
    i_redirect_valid = 1'b0;
    check_eq("t4_fault",   64'(o_fetch_fault), 64'd1);
    check_eq("t4_req",     64'(o_mem_req), 64'd0);
    check_eq("t4_valid",   64'(o_dec_valid), 64'd0);
    cyc(7);
    pulse();
    check_eq("t4_ignored", 64'(o_dec_valid), 64'd0);
    check_eq("t4_held",    64'(o_fetch_fault), 64'd1);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'h8000_0200;
    cyc(1);
    i_redirect_valid = 1'b0;
    check_eq("t4_clear",   64'(o_fetch_fault), 64'd0);
    check_eq("t4_req2",    64'(o_mem_req), 64'd1);
    check_eq("t4_addr",    o_mem_addr, 64'h8000_0200);
    cyc(7);
    pulse();
    check_eq("t4_pc",      o_dec_pc, 64'h8000_0200);
    i_dec_ready = 1'b0;

    // Test 5: push and pop together with one entry queued
    for (int k = 1; k <= 10; k++) begin
      cyc(7);
      i_dec_ready = 1'b1;
      pulse();
      i_dec_ready = 1'b0;
      check_eq($sformatf("t5_pc%0d", k),    o_dec_pc, 64'h8000_0200 + 64'(4 * k));
      check_eq($sformatf("t5_val%0d", k),   64'(o_dec_valid), 64'd1);
      check_eq($sformatf("t5_addr%0d", k),  o_mem_addr, 64'h8000_0204 + 64'(4 * k));
    end
    check_eq("t5_ins_last", 64'(o_dec_instr), 64'h0228_0F13);
    i_dec_ready = 1'b1;
    cyc(1);
    check_eq("t5_one_left", 64'(o_dec_valid), 64'd0);

    // Asynchronous reset mid-sequence
    i_dec_ready = 1'b0;
    cyc(7);
    pulse();
    cyc(3);
    #2;
    i_arst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    cyc(2);
    i_arst_n = 1'b1;
    cyc(2);
    check_eq("t5_restart_addr", o_mem_addr, RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
